seg_scan: RTL and testbench

SEG_SCAN -- requirements
Module: seg_scan

---
 rtl/seg_scan.sv | 83 ++++++++
 tb/tb_seg_scan.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/seg_scan.sv
// rtl/seg_scan.sv - four-digit multiplexed 7-segment scanner with shadow register and dead time
module seg_scan #(
    parameter int SCAN_DIV = 1000,
    parameter int DEAD     = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       en,
    input  logic       disp_on,
    input  logic [3:0] ew_10,
    input  logic [3:0] ew_1,
    input  logic [3:0] sn_10,
    input  logic [3:0] sn_1,
    output logic [3:0] an,
    output logic [6:0] seg
);

    localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] CNT_DEAD = CW'(DEAD);

    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    idx_q, idx_d;
    logic [15:0]   shadow_q, shadow_d;
    logic [3:0]    an_q, an_d;
    logic [6:0]    seg_q, seg_d;
    logic [3:0]    digit;

    function automatic logic [6:0] decode(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'h40;
            4'd1:    s = 7'h79;
            4'd2:    s = 7'h24;
            4'd3:    s = 7'h30;
            4'd4:    s = 7'h19;
            4'd5:    s = 7'h12;
            4'd6:    s = 7'h02;
            4'd7:    s = 7'h78;
            4'd8:    s = 7'h00;
            4'd9:    s = 7'h10;
            default: s = 7'h3F;
        endcase
        return s;
    endfunction

    always_comb begin
        cnt_d    = (cnt_q == CNT_LAST) ? '0 : cnt_q + CW'(1);
        idx_d    = (cnt_q == CNT_LAST) ? idx_q + 2'd1 : idx_q;
        shadow_d = en ? {sn_10, sn_1, ew_10, ew_1} : shadow_q;
        // Display reads the current shadow, so a load takes effect one cycle later.
        digit    = shadow_q[{idx_q, 2'b00} +: 4];
        an_d     = 4'hF;
        seg_d    = 7'h7F;
        if (disp_on && (cnt_q >= CNT_DEAD)) begin
            // Odd positions are tens digits; a zero there is blanked.
            if (!(idx_q[0] && (digit == 4'd0))) begin
                an_d  = ~(4'b0001 << idx_q);
                seg_d = decode(digit);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q    <= '0;
            idx_q    <= 2'd0;
            shadow_q <= 16'h0000;
            an_q     <= 4'hF;
            seg_q    <= 7'h7F;
        end else begin
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            shadow_q <= shadow_d;
            an_q     <= an_d;
            seg_q    <= seg_d;
        end
    end

    assign an  = an_q;
    assign seg = seg_q;

endmodule

// File: tb/tb_seg_scan.sv
// tb/tb_seg_scan.sv - directed self-checking bench for seg_scan
module tb_seg_scan;

    logic       clk;
    logic       reset;
    logic       en;
    logic       disp_on;
    logic [3:0] ew_10, ew_1, sn_10, sn_1;
    logic [3:0] an;
    logic [6:0] seg;

    int checks = 0;
    int errors = 0;

    seg_scan #(.SCAN_DIV(4), .DEAD(1)) dut (
        .clk     (clk),
        .reset   (reset),
        .en      (en),
        .disp_on (disp_on),
        .ew_10   (ew_10),
        .ew_1    (ew_1),
        .sn_10   (sn_10),
        .sn_1    (sn_1),
        .an      (an),
        .seg     (seg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL timeout: run did not complete within time limit");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step_chk(input string tag, input logic [3:0] ea, input logic [6:0] es);
        @(posedge clk);
        @(negedge clk);
        chk({tag, ".an"}, {4'h0, an}, {4'h0, ea});
        chk({tag, ".seg"}, {1'b0, seg}, {1'b0, es});
    endtask

    // One digit slot: one dead cycle then three lit cycles; any pending load strobe ends after the dead edge.
    task automatic digit(input string tag, input logic [3:0] ea, input logic [6:0] es);
        step_chk({tag, ".dead"}, 4'hF, 7'h7F);
        en = 1'b0;
        for (int i = 0; i < 3; i++) step_chk({tag, ".lit"}, ea, es);
    endtask

    initial begin
        reset = 1'b0; en = 1'b0; disp_on = 1'b1;
        ew_10 = 4'd0; ew_1 = 4'd0; sn_10 = 4'd0; sn_1 = 4'd0;
        repeat (2) @(negedge clk);
        chk("rst.an", {4'h0, an}, 8'h0F);
        chk("rst.seg", {1'b0, seg}, 8'h7F);

        // ew=57 sn=29 loaded on the first edge out of reset
        ew_10 = 4'd5; ew_1 = 4'd7; sn_10 = 4'd2; sn_1 = 4'd9; en = 1'b1;
        reset = 1'b1;
        for (int r = 0; r < 2; r++) begin
            digit("r57.d0", 4'hE, 7'h78);
            digit("r57.d1", 4'hD, 7'h12);
            digit("r29.d2", 4'hB, 7'h10);
            digit("r29.d3", 4'h7, 7'h24);
        end

        // ew=05: tens digit blanked
        ew_10 = 4'd0; ew_1 = 4'd5; en = 1'b1;
        digit("lz.d0", 4'hE, 7'h12);
        digit("lz.d1", 4'hF, 7'h7F);
        digit("lz.d2", 4'hB, 7'h10);
        digit("lz.d3", 4'h7, 7'h24);

        // sn_1 = C shows a dash
        sn_1 = 4'hC; en = 1'b1;
        digit("bad.d0", 4'hE, 7'h12);
        digit("bad.d1", 4'hF, 7'h7F);
        digit("bad.d2", 4'hB, 7'h3F);
        digit("bad.d3", 4'h7, 7'h24);

        // inputs change without en: display keeps the old shadow
        ew_10 = 4'd3; ew_1 = 4'd8; sn_10 = 4'd4; sn_1 = 4'd1;
        digit("hold.d0", 4'hE, 7'h12);
        digit("hold.d1", 4'hF, 7'h7F);
        digit("hold.d2", 4'hB, 7'h3F);
        digit("hold.d3", 4'h7, 7'h24);
        en = 1'b1;
        digit("upd.d0", 4'hE, 7'h00);
        digit("upd.d1", 4'hD, 7'h30);
        digit("upd.d2", 4'hB, 7'h79);
        step_chk("upd.d3.dead", 4'hF, 7'h7F);
        step_chk("upd.d3.lit", 4'h7, 7'h19);
        step_chk("upd.d3.lit", 4'h7, 7'h19);

        // load on the same edge as the idx 3->0 wrap
        ew_10 = 4'd6; ew_1 = 4'd9; en = 1'b1;
        step_chk("wrap.last", 4'h7, 7'h19);
        en = 1'b0;
        digit("wrap.d0", 4'hE, 7'h10);
        digit("wrap.d1", 4'hD, 7'h02);
        digit("wrap.d2", 4'hB, 7'h79);
        digit("wrap.d3", 4'h7, 7'h19);

        // display off for 10 cycles; counters keep running
        disp_on = 1'b0;
        for (int i = 0; i < 10; i++) step_chk("off", 4'hF, 7'h7F);
        disp_on = 1'b1;
        step_chk("on.d2", 4'hB, 7'h79);
        step_chk("on.d2", 4'hB, 7'h79);
        digit("on.d3", 4'h7, 7'h19);
        digit("on.d0", 4'hE, 7'h10);

        // asynchronous reset in the middle of a lit slot
        step_chk("pre.dead", 4'hF, 7'h7F);
        step_chk("pre.lit", 4'hD, 7'h02);
        #2;
        reset = 1'b0;
        #1;
        chk("arst.an", {4'h0, an}, 8'h0F);
        chk("arst.seg", {1'b0, seg}, 8'h7F);
        @(negedge clk);
        reset = 1'b1;
        step_chk("post.dead", 4'hF, 7'h7F);
        step_chk("post.lit", 4'hE, 7'h40);
        step_chk("post.lit", 4'hE, 7'h40);
        step_chk("post.lit", 4'hE, 7'h40);
        digit("post.d1", 4'hF, 7'h7F);
        digit("post.d2", 4'hB, 7'h40);
        digit("post.d3", 4'hF, 7'h7F);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
